// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: 2^DEPTH_FIFO-entry byte FIFO feeding a flop-driven serialiser.
// First start bit one edge after the write; writes while full are dropped and flag sticky overflow.
module uart_tx_fifo #(
    parameter int UART_CLK_HZ  = 140000000,
    parameter int UART_SCLK_HZ = 115200,
    parameter int DEPTH_FIFO   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            data_in,
    input  logic                  we,
    output logic                  full,
    output logic [DEPTH_FIFO:0]   count,
    output logic                  busy,
    output logic                  overflow,
    output logic                  uart_txd
);

    localparam int DIV     = UART_CLK_HZ / UART_SCLK_HZ;
    localparam int TW      = $clog2(DIV);
    localparam int ENTRIES = 1 << DEPTH_FIFO;
    localparam logic [TW-1:0]       TMR_TOP  = TW'(DIV - 1);
    localparam logic [DEPTH_FIFO:0] CNT_FULL = (DEPTH_FIFO + 1)'(ENTRIES);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]            mem [ENTRIES];
    logic [DEPTH_FIFO-1:0] wr_ptr;
    logic [DEPTH_FIFO-1:0] rd_ptr;

    state_t          state;
    state_t          state_n;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_n;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_n;
    logic [7:0]      shreg;
    logic [7:0]      shreg_n;
    logic            txd_n;
    logic            pop;
    logic            push;
    logic            fifo_ne;
    logic [DEPTH_FIFO:0] count_n;
    logic            full_n;

    assign fifo_ne = (count != '0);
    assign push    = we && !full;

    always_comb begin
        state_n   = state;
        timer_n   = (timer != '0) ? timer - TW'(1) : timer;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        txd_n     = uart_txd;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (fifo_ne) begin
                    pop     = 1'b1;
                    shreg_n = mem[rd_ptr];
                    txd_n   = 1'b0;
                    timer_n = TMR_TOP;
                    state_n = START;
                end
            end
            START: begin
                if (timer == '0) begin
                    txd_n     = shreg[0];
                    timer_n   = TMR_TOP;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (timer == '0) begin
                    timer_n = TMR_TOP;
                    if (bit_idx == 3'd7) begin
                        txd_n   = 1'b1;
                        state_n = STOP;
                    end else begin
                        shreg_n   = {1'b0, shreg[7:1]};
                        txd_n     = shreg[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so streamed bytes leave no idle gap.
                if (timer == '0) begin
                    if (fifo_ne) begin
                        pop     = 1'b1;
                        shreg_n = mem[rd_ptr];
                        txd_n   = 1'b0;
                        timer_n = TMR_TOP;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + (DEPTH_FIFO + 1)'(1);
            2'b01:   count_n = count - (DEPTH_FIFO + 1)'(1);
            default: count_n = count;
        endcase
        full_n = (count_n == CNT_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            uart_txd <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            uart_txd <= txd_n;
            count    <= count_n;
            full     <= full_n;
            busy     <= (state_n != IDLE) || (count_n != '0);
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_FIFO'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_FIFO'(1);
            end
            if (we && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed stimulus for uart_tx_fifo, scoreboarded against a frame-level line model.
module tb_uart_tx_fifo;

    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;
    localparam int CAP   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       full;
    logic [3:0] count;
    logic       busy;
    logic       overflow;
    logic       uart_txd;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .UART_CLK_HZ (16),
        .UART_SCLK_HZ(1),
        .DEPTH_FIFO  (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .we      (we),
        .full    (full),
        .count   (count),
        .busy    (busy),
        .overflow(overflow),
        .uart_txd(uart_txd)
    );

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    int  cyc = 0;
    int  free_at = 0;
    int  last_pop = -1;
    bit  m_ovf = 1'b0;
    bit  m_busy = 1'b0;
    bit  abort_frame = 1'b0;
    bit  mon_en = 1'b0;
    bit  mon_in_frame = 1'b0;
    int  n_frames = 0;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    // One clock: drive inputs away from the edge, then advance the reference model at the edge.
    task automatic step(input bit rs, input bit w, input logic [7:0] d);
        int   sz;
        bit   dp;
        exp_t e;
        @(negedge clk);
        reset   = rs;
        we      = w;
        data_in = d;
        @(posedge clk);
        cyc++;
        if (rs) begin
            mq.delete();
            exp_q.delete();
            m_ovf       = 1'b0;
            free_at     = cyc;
            last_pop    = -1;
            abort_frame = 1'b1;
        end else begin
            sz = mq.size();
            dp = (sz > 0) && (cyc >= free_at);
            if (w) begin
                if (sz < CAP) mq.push_back(d);
                else m_ovf = 1'b1;
            end
            if (dp) begin
                e.cyc = cyc;
                e.b   = mq.pop_front();
                exp_q.push_back(e);
                free_at  = cyc + FRAME;
                last_pop = cyc;
            end
        end
        m_busy = (cyc < free_at) || (mq.size() != 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 4000 && (m_busy || mon_in_frame || exp_q.size() != 0)) begin
            step(1'b0, 1'b0, 8'd0);
            n++;
        end
        if (n >= 4000) check("drain_timeout", 0, 1);
        step(1'b0, 1'b0, 8'd0);
    endtask

    // Monitor: status against the model every cycle, line against popped frames.
    always @(negedge clk) begin : monitor
        int         j;
        int         k;
        int         f_start;
        logic [7:0] f_byte;
        logic [7:0] f_dec;
        logic       lvl;
        exp_t       e;
        if (mon_en) begin
            if (abort_frame) begin
                mon_in_frame = 1'b0;
                abort_frame  = 1'b0;
            end
            check("count", int'(count), mq.size());
            check("full", int'(full), int'(mq.size() == CAP));
            check("busy", int'(busy), int'(m_busy));
            check("overflow", int'(overflow), int'(m_ovf));
            if (mon_in_frame) begin
                j   = cyc - f_start;
                k   = j / DIV;
                lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : f_byte[k-1];
                check("line_bit", int'(uart_txd), int'(lvl));
                if ((j % DIV) == DIV / 2 && k >= 1 && k <= 8) f_dec[k-1] = uart_txd;
                if (j == FRAME - 1) begin
                    check("decoded_byte", int'(f_dec), int'(f_byte));
                    mon_in_frame = 1'b0;
                end
            end else if (uart_txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("start_cycle", cyc, e.cyc);
                    mon_in_frame = 1'b1;
                    f_start      = cyc;
                    f_byte       = e.b;
                    f_dec        = 8'd0;
                    n_frames++;
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("missing_start", int'(uart_txd), 0);
                void'(exp_q.pop_front());
            end else begin
                check("idle_line", int'(uart_txd === 1'b1), 1);
            end
        end
    end

    initial begin
        int frames0;
        int n;
        int burst;
        bit rs;
        bit w;

        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        mon_en = 1'b1;
        repeat (1000) step(1'b0, 1'b0, 8'd0);

        step(1'b0, 1'b1, 8'h55);
        drain();

        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        drain();

        frames0 = n_frames;
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'h30 + i));
        #1;
        check("full_after_nine", int'(full), 1);
        check("overflow_before_tenth", int'(overflow), 0);
        step(1'b0, 1'b1, 8'hEE);
        #1;
        check("overflow_after_tenth", int'(overflow), 1);
        drain();
        check("nine_frames", n_frames - frames0, 9);

        step(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'hC0 + i));
        n = 0;
        while (cyc + 1 < free_at && n < 400) begin
            step(1'b0, 1'b0, 8'd0);
            n++;
        end
        step(1'b0, 1'b1, 8'h77);
        #1;
        check("ovf_on_pop_edge", int'(overflow), 1);
        check("count_on_pop_edge", int'(count), 7);
        drain();

        step(1'b0, 1'b1, 8'h5A);
        n = 0;
        while ((last_pop < 0 || cyc + 1 < last_pop + 40) && n < 400) begin
            step(1'b0, 1'b0, 8'd0);
            n++;
        end
        step(1'b1, 1'b0, 8'd0);
        #1;
        check("rst_txd", int'(uart_txd), 1);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_full", int'(full), 0);
        check("rst_overflow", int'(overflow), 0);
        step(1'b0, 1'b1, 8'h3C);
        drain();

        burst = 0;
        for (int i = 0; i < 6000; i++) begin
            rs = ($urandom_range(0, 1499) == 0);
            if (burst > 0) begin
                w = 1'b1;
                burst--;
            end else begin
                w = ($urandom_range(0, 99) < 3);
                if ($urandom_range(0, 399) == 0) burst = $urandom_range(3, 12);
            end
            step(rs, w, 8'($urandom_range(0, 255)));
        end
        drain();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
